cdi_pointer_device: RTL

- Parametrised serial pointing-device emulator for the CD-i input port.
- Converts MiSTer joystick bits into CD-i pointer byte frames on a bytestream source, paced at a configurable baud rate.
- Supports a relative mode (spoon-style deltas with two-stage acceleration) and an absolute mode (internally tracked, clamped 8-bit cursor position).
- Sits between the MiSTer HPS joystick input and the SLAVE/UART receive path, one instance per front-panel port.

---
 rtl/cdi_pointer_device.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/cdi_pointer_device.sv
// CD-i serial pointing-device emulator: turns MiSTer joystick bits into 3-byte pointer frames.
// Optional keepalive resend is enabled by defining POINTER_KEEPALIVE_EN.
module cdi_pointer_device #(
    parameter int         CLK_HZ        = 30000000,
    parameter int         BAUD          = 1200,
    parameter int         OC_TICKS      = 200000,
    parameter logic [7:0] REL_ID        = 8'hCA,
    parameter logic [7:0] ABS_ID        = 8'hCB,
    parameter int         SLOW_SPEED    = 2,
    parameter int         FAST_SPEED    = 8,
    parameter int         FAST_SPEED_OC = 7,
    parameter int         ACCEL_FRAMES  = 5,
    parameter int         LATCH_AHEAD   = 10
`ifdef POINTER_KEEPALIVE_EN
    ,
    parameter int         KEEPALIVE_SLOTS = 60
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mister_joystick,
    input  logic        rts,
    input  logic        overclock,
    input  logic        abs_mode,
    // serial_out_write is a one-clock strobe with serial_out_data valid in that same cycle;
    // the receiver has no backpressure, so every strobe is one delivered byte.
    output logic [7:0]  serial_out_data,
    output logic        serial_out_write,
    output logic [1:0]  dbg_state
);

    localparam int TICKS_NORM = CLK_HZ * 10 / BAUD;
    localparam int TICKS_MAX  = (TICKS_NORM > OC_TICKS) ? TICKS_NORM : OC_TICKS;
    localparam int CW         = $clog2(TICKS_MAX + 1);
    localparam int ACCEL_MAX  = ACCEL_FRAMES + 2;
    localparam int AW         = $clog2(ACCEL_MAX + 1);

    localparam logic [CW-1:0] T_NORM = CW'(TICKS_NORM);
    localparam logic [CW-1:0] T_OC   = CW'(OC_TICKS);

    typedef enum logic [1:0] {
        DEVICE_ID = 2'd0,
        BYTE0     = 2'd1,
        BYTE1     = 2'd2,
        BYTE2     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] reload;
    logic          slot_end;
    logic          mode_abs_q;
    logic [AW-1:0] accel_q;
    logic [7:0]    pos_x_q, pos_y_q;
    logic [7:0]    prev_x_q, prev_y_q;
    logic          prev_b1_q, prev_b2_q;
    logic [7:0]    frame0_q, frame1_q, frame2_q;
    logic          send_req_q;

    logic          right, left, down, up, b1, b2, any_dir;
    logic [7:0]    step, dx, dy;
    logic [9:0]    sum_x, sum_y;
    logic [7:0]    sat_x, sat_y, x_new, y_new;
    logic          send_new;
    logic          latch_frame;
    logic          send_now;
    logic          emit, take_frame;
    logic [7:0]    emit_data;
    logic          unused_joy;

    assign right   = mister_joystick[0];
    assign left    = mister_joystick[1];
    assign down    = mister_joystick[2];
    assign up      = mister_joystick[3];
    assign b2      = mister_joystick[4];
    assign b1      = mister_joystick[5];
    assign any_dir = |mister_joystick[3:0];
    assign unused_joy = &{1'b0, mister_joystick[15:6]};

    assign reload      = overclock ? T_OC : T_NORM;
    assign slot_end    = (cnt_q == '0);
    assign latch_frame = !rts && (state_q == BYTE0) && (cnt_q == CW'(LATCH_AHEAD));
    assign dbg_state   = state_q;

    // Direction decode; the negative direction wins when both are held.
    always_comb begin
        if (accel_q >= AW'(ACCEL_FRAMES)) begin
            step = overclock ? 8'(FAST_SPEED_OC) : 8'(FAST_SPEED);
        end else begin
            step = 8'(SLOW_SPEED);
        end
        dx = 8'h00;
        if (left) begin
            dx = 8'h00 - step;
        end else if (right) begin
            dx = step;
        end
        dy = 8'h00;
        if (up) begin
            dy = 8'h00 - step;
        end else if (down) begin
            dy = step;
        end
    end

    // Absolute cursor: 10-bit sum, bit 9 flags underflow and bit 8 overflow.
    always_comb begin
        sum_x = {2'b00, pos_x_q} + {{2{dx[7]}}, dx};
        sum_y = {2'b00, pos_y_q} + {{2{dy[7]}}, dy};
        sat_x = sum_x[9] ? 8'h00 : (sum_x[8] ? 8'hFF : sum_x[7:0]);
        sat_y = sum_y[9] ? 8'h00 : (sum_y[8] ? 8'hFF : sum_y[7:0]);
        x_new = mode_abs_q ? sat_x : dx;
        y_new = mode_abs_q ? sat_y : dy;
        send_new = (b1 != prev_b1_q) || (b2 != prev_b2_q) ||
                   (x_new != prev_x_q) || (y_new != prev_y_q) ||
                   (!mode_abs_q && ((x_new != 8'h00) || (y_new != 8'h00)));
    end

`ifdef POINTER_KEEPALIVE_EN
    logic [15:0] idle_q;
    assign send_now = send_req_q || (idle_q >= 16'(KEEPALIVE_SLOTS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else if (rts || take_frame) begin
            idle_q <= '0;
        end else if (slot_end && (state_q == BYTE0)) begin
            idle_q <= idle_q + 16'd1;
        end
    end
`else
    assign send_now = send_req_q;
`endif

    always_comb begin
        state_d    = state_q;
        emit       = 1'b0;
        emit_data  = 8'h00;
        take_frame = 1'b0;
        if (rts) begin
            state_d = DEVICE_ID;
        end else if (slot_end) begin
            case (state_q)
                DEVICE_ID: begin
                    emit      = 1'b1;
                    emit_data = mode_abs_q ? ABS_ID : REL_ID;
                    state_d   = BYTE0;
                end
                BYTE0: begin
                    if (send_now) begin
                        emit       = 1'b1;
                        emit_data  = frame0_q;
                        take_frame = 1'b1;
                        state_d    = BYTE1;
                    end
                end
                BYTE1: begin
                    emit      = 1'b1;
                    emit_data = frame1_q;
                    state_d   = BYTE2;
                end
                default: begin
                    emit      = 1'b1;
                    emit_data = frame2_q;
                    state_d   = BYTE0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DEVICE_ID;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q            <= T_NORM;
            serial_out_write <= 1'b0;
            serial_out_data  <= 8'h00;
            mode_abs_q       <= 1'b0;
            accel_q          <= '0;
            pos_x_q          <= 8'd128;
            pos_y_q          <= 8'd128;
            prev_x_q         <= 8'h00;
            prev_y_q         <= 8'h00;
            prev_b1_q        <= 1'b0;
            prev_b2_q        <= 1'b0;
            frame0_q         <= 8'h00;
            frame1_q         <= 8'h00;
            frame2_q         <= 8'h00;
            send_req_q       <= 1'b0;
        end else begin
            cnt_q            <= (rts || slot_end) ? reload : cnt_q - CW'(1);
            serial_out_write <= emit;
            if (emit) begin
                serial_out_data <= emit_data;
            end
            if (rts) begin
                mode_abs_q <= abs_mode;
            end
            if (latch_frame) begin
                frame0_q   <= {2'b11, b1, b2, y_new[7:6], x_new[7:6]};
                frame1_q   <= {2'b10, x_new[5:0]};
                frame2_q   <= {2'b10, y_new[5:0]};
                send_req_q <= send_new;
                if (mode_abs_q) begin
                    pos_x_q <= sat_x;
                    pos_y_q <= sat_y;
                end
                if (!any_dir) begin
                    accel_q <= '0;
                end else if (accel_q != AW'(ACCEL_MAX)) begin
                    accel_q <= accel_q + AW'(1);
                end
            end
            // The previous-sent values are recovered from the frame being sent.
            if (take_frame) begin
                prev_x_q  <= {frame0_q[1:0], frame1_q[5:0]};
                prev_y_q  <= {frame0_q[3:2], frame2_q[5:0]};
                prev_b1_q <= frame0_q[5];
                prev_b2_q <= frame0_q[4];
            end
        end
    end

endmodule
